// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file slice.
package regfile_pkg;
    localparam int RF_WIDTH      = 32;
    localparam int RF_REG_COUNT  = 32;
    localparam int RF_ADDR_WIDTH = $clog2(RF_REG_COUNT);

    typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
    typedef logic [RF_WIDTH-1:0]      rf_data_t;
endpackage

// File: rtl/regfile_if.sv
// Decode/writeback bus of the register file: flattened read and write ports.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int WIDTH      = RF_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1
);
    logic [NUM_RD-1:0]            rd_en;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*WIDTH-1:0]      rd_data;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WR*WIDTH-1:0]      wr_data;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/regfile_rd_port.sv
// One registered read port: array mux, optional same-cycle write bypass
// (REGFILE_BYPASS_EN), zero-register force and enable-gated output register.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int WIDTH     = RF_WIDTH,
    parameter int REG_COUNT = RF_REG_COUNT,
    parameter int NUM_WR    = 1,
    parameter int ZERO_REG  = 1,
    localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [REG_COUNT-1:0][WIDTH-1:0]   mem,
    input  logic                              rd_en,
    input  logic [ADDR_WIDTH-1:0]             rd_addr,
`ifdef REGFILE_BYPASS_EN
    input  logic [NUM_WR-1:0]                 wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]      wr_addr,
    input  logic [NUM_WR*WIDTH-1:0]           wr_data,
`endif
    output logic [WIDTH-1:0]                  rd_data
);
    logic [WIDTH-1:0] rd_next;

    always_comb begin
        rd_next = mem[rd_addr];
`ifdef REGFILE_BYPASS_EN
        // Ascending scan so the highest-index matching writer is forwarded.
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr)
                rd_next = wr_data[w*WIDTH +: WIDTH];
        end
`endif
        if (ZERO_REG != 0 && rd_addr == '0)
            rd_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= rd_next;
    end
endmodule

// File: rtl/regfile_mp.sv
// Parametrised N-read/M-write register file with optional hardwired x0.
// Define REGFILE_BYPASS_EN to forward same-cycle writes into read data.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH     = RF_WIDTH,
    parameter int REG_COUNT = RF_REG_COUNT,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 1,
    parameter int ZERO_REG  = 1
) (
    input logic       clk,
    input logic       rst,
    regfile_if.slave  bus
);
    localparam int ADDR_WIDTH = $clog2(REG_COUNT);

    logic [REG_COUNT-1:0][WIDTH-1:0] mem;
    logic [NUM_RD-1:0][WIDTH-1:0]    rd_q;

    // Later loop iterations override earlier ones, so the highest write port wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else begin
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (bus.wr_en[w] &&
                    !(ZERO_REG != 0 && bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == '0))
                    mem[bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wr_data[w*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_rd_port #(
            .WIDTH    (WIDTH),
            .REG_COUNT(REG_COUNT),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .clk    (clk),
            .rst    (rst),
            .mem    (mem),
            .rd_en  (bus.rd_en[p]),
            .rd_addr(bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
`ifdef REGFILE_BYPASS_EN
            .wr_en  (bus.wr_en),
            .wr_addr(bus.wr_addr),
            .wr_data(bus.wr_data),
`endif
            .rd_data(rd_q[p])
        );
    end

    assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (2R/2W with x0 hardwired, 2R/1W with ordinary x0)
// checked every cycle against an array model, plus directed literal expectations.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  re;
    logic [4:0]  ra [2];
    logic [1:0]  we;
    logic [4:0]  wa [2];
    logic [31:0] wd [2];

    regfile_if #(.WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2)) ifa ();
    regfile_if #(.WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(1)) ifb ();

    assign ifa.rd_en   = re;
    assign ifa.rd_addr = {ra[1], ra[0]};
    assign ifa.wr_en   = we;
    assign ifa.wr_addr = {wa[1], wa[0]};
    assign ifa.wr_data = {wd[1], wd[0]};
    assign ifb.rd_en   = re;
    assign ifb.rd_addr = {ra[1], ra[0]};
    assign ifb.wr_en   = we[0];
    assign ifb.wr_addr = wa[0];
    assign ifb.wr_data = wd[0];

    regfile_mp #(.WIDTH(32), .REG_COUNT(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    regfile_mp #(.WIDTH(32), .REG_COUNT(32), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Model: register contents as plain arrays, expected read data per port.
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];
    logic [31:0] exp_a [2];
    logic [31:0] exp_b [2];

    function automatic logic [31:0] model_read(input logic [31:0] m [32], input logic [4:0] a,
                                               input bit zero, input int nwr);
        logic [31:0] v = m[a];
        if (BYPASS)
            for (int w = 0; w < nwr; w++)
                if (we[w] && wa[w] == a) v = wd[w];
        if (zero && a == 5'd0) v = 32'd0;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem_a[i] = 32'd0;
                mem_b[i] = 32'd0;
            end
            for (int p = 0; p < 2; p++) begin
                exp_a[p] = 32'd0;
                exp_b[p] = 32'd0;
            end
        end else begin
            for (int p = 0; p < 2; p++)
                if (re[p]) begin
                    exp_a[p] = model_read(mem_a, ra[p], 1'b1, 2);
                    exp_b[p] = model_read(mem_b, ra[p], 1'b0, 1);
                end
            for (int w = 0; w < 2; w++)
                if (we[w] && wa[w] != 5'd0) mem_a[wa[w]] = wd[w];
            if (we[0]) mem_b[wa[0]] = wd[0];
        end
    end

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            check($sformatf("model_a_rd%0d", p), ifa.rd_data[p*32 +: 32], exp_a[p]);
            check($sformatf("model_b_rd%0d", p), ifb.rd_data[p*32 +: 32], exp_b[p]);
        end
    end

    task automatic drive(input logic [1:0] r, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
        re = r; ra[0] = r0; ra[1] = r1;
        we = w; wa[0] = a0; wd[0] = d0; wa[1] = a1; wd[1] = d1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        re = '0; we = '0;
        ra[0] = '0; ra[1] = '0; wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
        repeat (3) @(negedge clk);
        check("reset_a_rd0", ifa.rd_data[31:0], 32'd0);
        check("reset_b_rd1", ifb.rd_data[63:32], 32'd0);
        rst = 1'b0;

        // Reset mid-operation
        drive(2'b01, 5'd5, 5'd0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
        check("t1_wr_rd_a", ifa.rd_data[31:0], BYPASS ? 32'hDEADBEEF : 32'd0);
        drive(2'b11, 5'd5, 5'd5, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        check("t1_pre_rst_a", ifa.rd_data[31:0], 32'hDEADBEEF);
        check("t1_pre_rst_b", ifb.rd_data[63:32], 32'hDEADBEEF);
        #2 rst = 1'b1;
        #1;
        check("t1_async_a0", ifa.rd_data[31:0], 32'd0);
        check("t1_async_a1", ifa.rd_data[63:32], 32'd0);
        check("t1_async_b0", ifb.rd_data[31:0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(2'b11, 5'd5, 5'd5, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        check("t1_post_rst_a", ifa.rd_data[31:0], 32'd0);
        check("t1_post_rst_b", ifb.rd_data[63:32], 32'd0);

        // Basic write then read on both ports
        drive(2'b00, 5'd0, 5'd0, 2'b01, 5'd7, 32'h12345678, 5'd0, 32'd0);
        drive(2'b11, 5'd7, 5'd7, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        check("t2_a_rd0", ifa.rd_data[31:0], 32'h12345678);
        check("t2_a_rd1", ifa.rd_data[63:32], 32'h12345678);

        // x0: hardwired on dut_a, ordinary storage on dut_b
        drive(2'b11, 5'd0, 5'd0, 2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'd0);
        check("t3_a_same_cycle", ifa.rd_data[31:0], 32'd0);
        check("t3_b_same_cycle", ifb.rd_data[31:0], BYPASS ? 32'hFFFFFFFF : 32'd0);
        drive(2'b11, 5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        check("t3_a_x0", ifa.rd_data[63:32], 32'd0);
        check("t3_b_x0", ifb.rd_data[63:32], 32'hFFFFFFFF);

        // Read/write collision
        drive(2'b00, 5'd0, 5'd0, 2'b01, 5'd3, 32'hAAAA0000, 5'd0, 32'd0);
        drive(2'b01, 5'd3, 5'd0, 2'b01, 5'd3, 32'h00005555, 5'd0, 32'd0);
        check("t4_a_collide", ifa.rd_data[31:0], BYPASS ? 32'h00005555 : 32'hAAAA0000);
        check("t4_b_collide", ifb.rd_data[31:0], BYPASS ? 32'h00005555 : 32'hAAAA0000);
        drive(2'b01, 5'd3, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        check("t4_a_after", ifa.rd_data[31:0], 32'h00005555);

        // Write-port conflict: port 1 wins on dut_a
        drive(2'b00, 5'd0, 5'd0, 2'b11, 5'd9, 32'h00001111, 5'd9, 32'h00002222);
        drive(2'b11, 5'd9, 5'd9, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        check("t5_a_winner", ifa.rd_data[31:0], 32'h00002222);
        check("t5_a_winner1", ifa.rd_data[63:32], 32'h00002222);
        check("t5_b_single", ifb.rd_data[31:0], 32'h00001111);

        // Hold with rd_en low while the held registers are overwritten
        drive(2'b11, 5'd7, 5'd3, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            drive(2'b00, 5'($urandom), 5'($urandom), 2'b11, 5'd7, $urandom, 5'd3, $urandom);
            check("t6_hold_a0", ifa.rd_data[31:0], 32'h12345678);
            check("t6_hold_a1", ifa.rd_data[63:32], 32'h00005555);
            check("t6_hold_b0", ifb.rd_data[31:0], 32'h12345678);
        end

        // Random traffic, biased toward a few addresses to provoke collisions
        for (int i = 0; i < 128; i++) begin
            logic [4:0] r0, r1, a0, a1;
            r0 = ($urandom & 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            r1 = ($urandom & 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            a0 = ($urandom & 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            a1 = ($urandom & 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            drive(2'($urandom), r0, r1, 2'($urandom), a0, $urandom, a1, $urandom);
        end
        drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
